// File: rtl/uart_fifo_cfg.sv
// uart_fifo_cfg: full-duplex UART with runtime parity/stop selection,
// majority-vote RX sampling, error/break/overrun detection and small
// show-ahead FIFOs on the host side of both directions.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. tx_ready and rx_valid depend only on registered state, so
// the host may sample them anywhere in the cycle. rx_data and the error flags
// show the head entry while rx_valid is high and read as zero otherwise.
module uart_fifo_cfg #(
  parameter int DATA_W   = 8,
  parameter int FIFO_AW  = 2,
  parameter int NUM_SYNC = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic              rx_in,
  output logic              tx_out,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_idle,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  input  logic              clr_overrun,
  output logic              rx_break
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = FIFO_AW + 1;
  localparam int RXW   = DATA_W + 2;
  localparam logic [3:0] LAST_IDX = 4'(DATA_W - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_HUNT, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  // ---------------------------------------------------------------- TX FIFO
  logic [DATA_W-1:0] tx_mem_q [DEPTH];
  logic [PW-1:0]     tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic              tx_full, tx_empty, tx_we, tx_pop;
  logic [DATA_W-1:0] tx_head;

  assign tx_full  = (tx_wr_q[FIFO_AW] != tx_rd_q[FIFO_AW]) &&
                    (tx_wr_q[FIFO_AW-1:0] == tx_rd_q[FIFO_AW-1:0]);
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_we    = tx_valid && !tx_full;
  assign tx_head  = tx_mem_q[tx_rd_q[FIFO_AW-1:0]];
  assign tx_ready = !tx_full;

  // TX FIFO pointer update: a write while full is dropped by tx_ready gating.
  always_comb begin
    tx_wr_d = tx_wr_q;
    tx_rd_d = tx_rd_q;
    if (tx_we)  tx_wr_d = tx_wr_q + PW'(1);
    if (tx_pop) tx_rd_d = tx_rd_q + PW'(1);
  end

  // TX FIFO storage write.
  always_ff @(posedge clk) begin
    if (tx_we) tx_mem_q[tx_wr_q[FIFO_AW-1:0]] <= tx_data;
  end

  // ---------------------------------------------------------------- TX FSM
  tx_state_t         tx_state_q, tx_state_d;
  logic [15:0]       tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [3:0]        tx_idx_q, tx_idx_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              tx_pbit_q, tx_pbit_d, tx_par_en_q, tx_par_en_d;
  logic              tx_stop2_q, tx_stop2_d, tx_second_q, tx_second_d;
  logic              tx_out_q, tx_out_d;
  logic              tx_bit_done, tx_load;

  assign tx_bit_done = (tx_cnt_q == tx_div_q - 16'd1);

  // TX next state: one bit per baud_div cycles; config captured when a word is loaded.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_div_d    = tx_div_q;
    tx_idx_d    = tx_idx_q;
    tx_shift_d  = tx_shift_q;
    tx_pbit_d   = tx_pbit_q;
    tx_par_en_d = tx_par_en_q;
    tx_stop2_d  = tx_stop2_q;
    tx_second_d = tx_second_q;
    tx_load     = 1'b0;
    tx_pop      = 1'b0;
    case (tx_state_q)
      TX_IDLE: if (!tx_empty) tx_load = 1'b1;
      TX_START: begin
        tx_cnt_d = tx_cnt_q + 16'd1;
        if (tx_bit_done) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_cnt_d = tx_cnt_q + 16'd1;
        if (tx_bit_done) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift_q >> 1;
          tx_idx_d   = tx_idx_q + 4'd1;
          if (tx_idx_q == LAST_IDX) begin
            tx_second_d = 1'b0;
            tx_state_d  = tx_par_en_q ? TX_PARITY : TX_STOP;
          end
        end
      end
      TX_PARITY: begin
        tx_cnt_d = tx_cnt_q + 16'd1;
        if (tx_bit_done) begin
          tx_cnt_d    = '0;
          tx_second_d = 1'b0;
          tx_state_d  = TX_STOP;
        end
      end
      TX_STOP: begin
        tx_cnt_d = tx_cnt_q + 16'd1;
        if (tx_bit_done) begin
          tx_cnt_d = '0;
          if (tx_stop2_q && !tx_second_q) tx_second_d = 1'b1;
          else if (!tx_empty)             tx_load     = 1'b1;
          else                            tx_state_d  = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Loading from the final stop cycle gives back-to-back frames with no gap.
    if (tx_load) begin
      tx_pop      = 1'b1;
      tx_state_d  = TX_START;
      tx_cnt_d    = '0;
      tx_shift_d  = tx_head;
      tx_div_d    = baud_div;
      tx_par_en_d = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      tx_pbit_d   = (parity_mode == 2'b01) ? ~^tx_head : ^tx_head;
      tx_stop2_d  = stop2;
    end
    // Line level follows the state one cycle later, so every level lasts baud_div cycles.
    case (tx_state_q)
      TX_START:  tx_out_d = 1'b0;
      TX_DATA:   tx_out_d = tx_shift_q[0];
      TX_PARITY: tx_out_d = tx_pbit_q;
      default:   tx_out_d = 1'b1;
    endcase
  end

  assign tx_out  = tx_out_q;
  assign tx_idle = tx_empty && (tx_state_q == TX_IDLE);

  // ---------------------------------------------------------------- RX FSM
  logic [NUM_SYNC-1:0] rx_sync_q, rx_sync_d;
  logic                rx_s, rx_prev_q;
  rx_state_t           rx_state_q, rx_state_d;
  logic [15:0]         rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_mid_q, rx_mid_d;
  logic [3:0]          rx_idx_q, rx_idx_d;
  logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
  logic [1:0]          rx_smp_q, rx_smp_d;
  logic                rx_pbit_q, rx_pbit_d, rx_par_en_q, rx_par_en_d;
  logic                rx_odd_q, rx_odd_d, rx_break_q, rx_break_d;
  logic                rx_vote, rx_at_s0, rx_at_s1, rx_at_vote, rx_done;
  logic                rx_push, rx_fe, rx_pe;

  assign rx_sync_d  = {rx_sync_q[NUM_SYNC-2:0], rx_in};
  assign rx_s       = rx_sync_q[NUM_SYNC-1];
  assign rx_at_s0   = (rx_cnt_q == rx_mid_q - 16'd1);
  assign rx_at_s1   = (rx_cnt_q == rx_mid_q);
  assign rx_at_vote = (rx_cnt_q == rx_mid_q + 16'd1);
  assign rx_done    = (rx_cnt_q == rx_div_q - 16'd1);
  assign rx_vote    = (rx_smp_q[0] & rx_smp_q[1]) | (rx_smp_q[0] & rx_s) |
                      (rx_smp_q[1] & rx_s);

  // RX next state: count from the falling edge, vote three samples around mid-bit.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_div_d    = rx_div_q;
    rx_mid_d    = rx_mid_q;
    rx_idx_d    = rx_idx_q;
    rx_shift_d  = rx_shift_q;
    rx_smp_d    = rx_smp_q;
    rx_pbit_d   = rx_pbit_q;
    rx_par_en_d = rx_par_en_q;
    rx_odd_d    = rx_odd_q;
    rx_break_d  = 1'b0;
    rx_push     = 1'b0;
    rx_fe       = 1'b0;
    rx_pe       = 1'b0;
    if (rx_state_q != RX_HUNT && rx_state_q != RX_WAIT_HIGH) begin
      rx_cnt_d = rx_done ? 16'd0 : rx_cnt_q + 16'd1;
      if (rx_at_s0) rx_smp_d[0] = rx_s;
      if (rx_at_s1) rx_smp_d[1] = rx_s;
    end
    case (rx_state_q)
      RX_HUNT: begin
        // The edge-detect cycle is count 0 of the start bit.
        if (rx_prev_q && !rx_s) begin
          rx_state_d  = RX_START;
          rx_cnt_d    = 16'd1;
          rx_div_d    = baud_div;
          rx_mid_d    = baud_div >> 1;
          rx_par_en_d = (parity_mode == 2'b01) || (parity_mode == 2'b10);
          rx_odd_d    = (parity_mode == 2'b01);
        end
      end
      RX_START: begin
        if (rx_at_vote && rx_vote) rx_state_d = RX_HUNT;
        else if (rx_done) begin
          rx_idx_d   = '0;
          rx_state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_at_vote) rx_shift_d = {rx_vote, rx_shift_q[DATA_W-1:1]};
        if (rx_done) begin
          rx_idx_d = rx_idx_q + 4'd1;
          if (rx_idx_q == LAST_IDX) rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (rx_at_vote) rx_pbit_d = rx_vote;
        if (rx_done)    rx_state_d = RX_STOP;
      end
      RX_STOP: begin
        // Only the first stop bit is examined; the frame is pushed at its vote.
        if (rx_at_vote) begin
          rx_push    = 1'b1;
          rx_fe      = !rx_vote;
          rx_pe      = rx_par_en_q && ((^rx_shift_q ^ rx_pbit_q) != rx_odd_q);
          rx_break_d = !rx_vote && (rx_shift_q == '0) && (!rx_par_en_q || !rx_pbit_q);
          rx_state_d = rx_vote ? RX_HUNT : RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: if (rx_s) rx_state_d = RX_HUNT;
      default: rx_state_d = RX_HUNT;
    endcase
  end

  assign rx_break = rx_break_q;

  // ---------------------------------------------------------------- RX FIFO
  logic [RXW-1:0] rx_mem_q [DEPTH];
  logic [PW-1:0]  rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic           rx_full, rx_empty, rx_we, rx_pop, rx_ovr_q, rx_ovr_d;
  logic [RXW-1:0] rx_head;

  assign rx_full  = (rx_wr_q[FIFO_AW] != rx_rd_q[FIFO_AW]) &&
                    (rx_wr_q[FIFO_AW-1:0] == rx_rd_q[FIFO_AW-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_pop   = !rx_empty && rx_ready;
  // A push into a full FIFO still lands if the head leaves in the same cycle.
  assign rx_we    = rx_push && (!rx_full || rx_pop);
  assign rx_head  = rx_mem_q[rx_rd_q[FIFO_AW-1:0]];

  // RX FIFO pointers and sticky overrun (a new drop beats a clear).
  always_comb begin
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    rx_ovr_d = rx_ovr_q;
    if (rx_we)  rx_wr_d = rx_wr_q + PW'(1);
    if (rx_pop) rx_rd_d = rx_rd_q + PW'(1);
    if (clr_overrun) rx_ovr_d = 1'b0;
    if (rx_push && !rx_we) rx_ovr_d = 1'b1;
  end

  // RX FIFO storage write.
  always_ff @(posedge clk) begin
    if (rx_we) rx_mem_q[rx_wr_q[FIFO_AW-1:0]] <= {rx_fe, rx_pe, rx_shift_q};
  end

  assign rx_valid      = !rx_empty;
  assign rx_data       = rx_valid ? rx_head[DATA_W-1:0] : '0;
  assign rx_parity_err = rx_valid && rx_head[DATA_W];
  assign rx_frame_err  = rx_valid && rx_head[DATA_W+1];
  assign rx_overrun    = rx_ovr_q;

  // ---------------------------------------------------------------- registers
  // All control state; reset abandons any frame in progress and idles the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_q     <= '0;
      tx_rd_q     <= '0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_div_q    <= 16'd16;
      tx_idx_q    <= '0;
      tx_shift_q  <= '0;
      tx_pbit_q   <= 1'b0;
      tx_par_en_q <= 1'b0;
      tx_stop2_q  <= 1'b0;
      tx_second_q <= 1'b0;
      tx_out_q    <= 1'b1;
      rx_sync_q   <= '1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_HUNT;
      rx_cnt_q    <= '0;
      rx_div_q    <= 16'd16;
      rx_mid_q    <= 16'd8;
      rx_idx_q    <= '0;
      rx_shift_q  <= '0;
      rx_smp_q    <= '0;
      rx_pbit_q   <= 1'b0;
      rx_par_en_q <= 1'b0;
      rx_odd_q    <= 1'b0;
      rx_break_q  <= 1'b0;
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      rx_ovr_q    <= 1'b0;
    end else begin
      tx_wr_q     <= tx_wr_d;
      tx_rd_q     <= tx_rd_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_div_q    <= tx_div_d;
      tx_idx_q    <= tx_idx_d;
      tx_shift_q  <= tx_shift_d;
      tx_pbit_q   <= tx_pbit_d;
      tx_par_en_q <= tx_par_en_d;
      tx_stop2_q  <= tx_stop2_d;
      tx_second_q <= tx_second_d;
      tx_out_q    <= tx_out_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_s;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_div_q    <= rx_div_d;
      rx_mid_q    <= rx_mid_d;
      rx_idx_q    <= rx_idx_d;
      rx_shift_q  <= rx_shift_d;
      rx_smp_q    <= rx_smp_d;
      rx_pbit_q   <= rx_pbit_d;
      rx_par_en_q <= rx_par_en_d;
      rx_odd_q    <= rx_odd_d;
      rx_break_q  <= rx_break_d;
      rx_wr_q     <= rx_wr_d;
      rx_rd_q     <= rx_rd_d;
      rx_ovr_q    <= rx_ovr_d;
    end
  end

endmodule
